// File: rtl/ternary_pkg.sv
// Shared definitions for the ternary arithmetic blocks.
//   - Trit codes: T0/T1/T2 are the legal digits 0/1/2, TX is the illegal code.
//   - state_t: control states of the digit-serial subtractor.
//   - trit_legal(): 1 when a 2-bit code is a legal trit.
package ternary_pkg;

  localparam logic [1:0] T0 = 2'b00;
  localparam logic [1:0] T1 = 2'b01;
  localparam logic [1:0] T2 = 2'b10;
  localparam logic [1:0] TX = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic trit_legal(input logic [1:0] t);
    return t != TX;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-trit ternary full subtractor: computes A - B - C for one digit.
// Ports:
//   A, B   in  2 : minuend and subtrahend trits (legal codes only)
//   C      in  2 : incoming borrow trit (T0 or T1)
//   diff   out 2 : (A - B - C) mod 3
//   b_out  out 2 : T1 when A - B - C is negative, else T0
module full_subtractor
  import ternary_pkg::*;
(
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic [1:0] C,
  output logic [1:0] diff,
  output logic [1:0] b_out
);

  // Bias by 3 so the intermediate stays non-negative: range is 0..5.
  logic [2:0] biased;

  // NOTE: every output gets a default at the top of the always_comb block,
  // so no path can leave a value unassigned and infer a latch.
  always_comb begin
    diff   = T0;
    b_out  = T0;
    biased = 3'd3 + {1'b0, A} - {1'b0, B} - {1'b0, C};
    if (biased >= 3'd3) begin
      diff  = 2'(biased - 3'd3);
      b_out = T0;
    end else begin
      diff  = biased[1:0];
      b_out = T1;
    end
  end

endmodule

// File: rtl/ternary_serial_subtractor.sv
// Digit-serial N-trit ternary subtractor, A - B, one trit per clock, LSB first.
// Operands are captured on an input handshake, walked through a single
// full_subtractor cell, and the result is presented on an output handshake.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (accepted only in IDLE)
//   a, b        in  2N   : minuend / subtrahend, trit k at bits [2k+1:2k]
//   out_valid / out_ready: result handshake (held in DONE until accepted)
//   diff        out 2N   : (A - B) mod 3^N
//   borrow_out  out 2    : T1 exactly when A < B
//   err         out 1    : a captured operand trit was the illegal code
// N must be at least 2.
module ternary_serial_subtractor
  import ternary_pkg::*;
#(
  parameter int N = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] a,
  input  logic [2*N-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] diff,
  output logic [1:0]     borrow_out,
  output logic           err
);

  localparam int             CNT_W      = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

  state_t           state_q, state_d;
  logic [2*N-1:0]   a_sr_q, b_sr_q, result_q;
  logic [2*N-1:0]   a_clean, b_clean;
  logic [1:0]       borrow_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             operand_bad;
  logic             accept, step;
  logic [1:0]       cell_diff, cell_borrow;

  // Illegal trits are replaced by 0 at capture; the flag records that it happened.
  always_comb begin
    a_clean     = '0;
    b_clean     = '0;
    operand_bad = 1'b0;
    for (int k = 0; k < N; k++) begin
      a_clean[2*k +: 2] = trit_legal(a[2*k +: 2]) ? a[2*k +: 2] : T0;
      b_clean[2*k +: 2] = trit_legal(b[2*k +: 2]) ? b[2*k +: 2] : T0;
      operand_bad = operand_bad | ~trit_legal(a[2*k +: 2]) | ~trit_legal(b[2*k +: 2]);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (cnt_q == LAST_DIGIT) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The current digit is always the low trit of each operand shift register.
  full_subtractor u_cell (
    .A     (a_sr_q[1:0]),
    .B     (b_sr_q[1:0]),
    .C     (borrow_q),
    .diff  (cell_diff),
    .b_out (cell_borrow)
  );

  // NOTE: the operand and result registers are reset as well, because diff,
  // borrow_out and err are driven straight from them and must read 0 in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      result_q <= '0;
      borrow_q <= T0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      a_sr_q   <= a_clean;
      b_sr_q   <= b_clean;
      result_q <= '0;
      borrow_q <= T0;
      cnt_q    <= '0;
      err_q    <= operand_bad;
    end else if (step) begin
      a_sr_q   <= a_sr_q >> 2;
      b_sr_q   <= b_sr_q >> 2;
      // After N shifts the first (LSB) digit has travelled down to bits [1:0].
      result_q <= {cell_diff, result_q[2*N-1:2]};
      borrow_q <= cell_borrow;
      cnt_q    <= (cnt_q == LAST_DIGIT) ? '0 : cnt_q + 1'b1;
    end
  end

  assign diff       = result_q;
  assign borrow_out = borrow_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ternary_serial_subtractor.sv
// Self-checking bench for ternary_serial_subtractor with N = 3.
// Directed vectors from a table, randomized operands against an integer
// reference model, plus backpressure and mid-operation reset sequences.
module tb_ternary_serial_subtractor;

  localparam int N = 3;
  localparam int W = 2 * N;

  logic         clk, rst;
  logic         in_valid, in_ready, out_valid, out_ready, err;
  logic [W-1:0] a, b, diff;
  logic [1:0]   borrow_out;

  int checks = 0;
  int errors = 0;

  ternary_serial_subtractor #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic [1:0]   borrow;
    logic         err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference: decode to integers, subtract, wrap modulo 3^N, re-encode.
  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                output logic [W-1:0] dv, output logic [1:0] bo,
                                output logic ev);
    int aval = 0, bval = 0, d, modulus = 1;
    logic [1:0] t;
    ev = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      t = av[2*k +: 2];
      if (t == 2'b11) begin ev = 1'b1; t = 2'b00; end
      aval = aval * 3 + int'(t);
      t = bv[2*k +: 2];
      if (t == 2'b11) begin ev = 1'b1; t = 2'b00; end
      bval = bval * 3 + int'(t);
      modulus = modulus * 3;
    end
    d  = aval - bval;
    bo = (d < 0) ? 2'b01 : 2'b00;
    if (d < 0) d = d + modulus;
    dv = '0;
    for (int k = 0; k < N; k++) begin
      dv[2*k +: 2] = 2'(d % 3);
      d = d / 3;
    end
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_accept", in_ready, 1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    check("in_ready_low_after_accept", in_ready, 0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, N);
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after_release", in_ready, 1);
    check("out_valid_after_release", out_valid, 0);
  endtask

  task automatic run_and_check(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic [W-1:0] ed, input logic [1:0] eb, input logic ee);
    int lat;
    start_op(av, bv);
    wait_done(lat);
    check("diff", diff, ed);
    check("borrow_out", borrow_out, eb);
    check("err", err, ee);
    finish_op();
  endtask

  vec_t         vecs[8];
  logic [W-1:0] md, ra, rb, hold;
  logic [1:0]   mb;
  logic         me;
  int           lat;
  bit           saw_valid;

  initial begin
    vecs[0] = '{6'b100100, 6'b010010, 6'b010001, 2'b00, 1'b0};  // 21 - 11 = 10
    vecs[1] = '{6'b000000, 6'b000001, 6'b101010, 2'b01, 1'b0};  // underflow
    vecs[2] = '{6'b101010, 6'b101010, 6'b000000, 2'b00, 1'b0};  // equal
    vecs[3] = '{6'b000011, 6'b000000, 6'b000000, 2'b00, 1'b1};  // illegal a trit
    vecs[4] = '{6'b101010, 6'b000000, 6'b101010, 2'b00, 1'b0};  // 26 - 0
    vecs[5] = '{6'b000000, 6'b101010, 6'b000001, 2'b01, 1'b0};  // 0 - 26 -> 1
    vecs[6] = '{6'b010101, 6'b000010, 6'b010010, 2'b00, 1'b0};  // 13 - 2 = 11
    vecs[7] = '{6'b000001, 6'b110000, 6'b000001, 2'b00, 1'b1};  // illegal b trit

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #2 rst = 1'b1;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_diff", diff, 0);
    check("reset_borrow_out", borrow_out, 0);
    check("reset_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_and_check(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow, vecs[i].err);

    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        ra = W'($urandom);
        rb = W'($urandom);
      end else begin
        for (int k = 0; k < N; k++) begin
          ra[2*k +: 2] = 2'($urandom_range(0, 2));
          rb[2*k +: 2] = 2'($urandom_range(0, 2));
        end
      end
      model(ra, rb, md, mb, me);
      run_and_check(ra, rb, md, mb, me);
    end

    // Backpressure: DONE holds while in_valid pulses are ignored.
    model(6'b011000, 6'b100001, md, mb, me);
    start_op(6'b011000, 6'b100001);
    wait_done(lat);
    hold = diff;
    check("bp_diff", diff, md);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_diff_stable", diff, hold);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    check("bp_diff_final", diff, md);
    check("bp_borrow_final", borrow_out, mb);
    finish_op();

    // Reset on the second RUN cycle, with err set and a partial result present.
    start_op(6'b100011, 6'b000001);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_diff", diff, 0);
    check("midrst_borrow_out", borrow_out, 0);
    check("midrst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int c = 0; c < N + 3; c++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("midrst_no_out_valid", saw_valid, 0);
    check("midrst_in_ready_after", in_ready, 1);
    run_and_check(vecs[0].a, vecs[0].b, vecs[0].diff, vecs[0].borrow, vecs[0].err);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
